hit_accum: RTL and testbench
============================

HIT_ACCUM -- requirements
Module: hit_accum

Interface
REQ-001 SHALL have parameter ID_W, default 16, triangle index width.
REQ-002 SHALL have parameter CNT_W, default 6, outstanding-test counter width.
REQ-003 SHALL have ports (clock and reset first):
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin new ray; latch tmax_init
- tmax_init  input  32  initial ray tmax, IEEE-754 single
- issue  input  1  one intersection test issued to ist this cycle
- last  input  1  no further issues for this ray; may coincide with issue
- done  input  1  ist result strobe
- isected  input  1  ist hit flag, qualified by done
- t, u, v  input  32 each  ist hit parameters, IEEE-754 single
- prim_id  input  ID_W  triangle index for the returning result
- tmax_out  output  32  current closest t, fed back to ist tmax
- busy  output  1  high in ACCUM or REPORT
- res_valid  output  1  final hit record valid
- res_ready  input  1  consumer accepts the record
- res_hit, res_t, res_u, res_v, res_id  output  1/32/32/32/ID_W  final record

Function
REQ-004 SHALL implement states IDLE, ACCUM, REPORT.
REQ-005 SHALL, in IDLE on start, load tmax_out=tmax_init, clear res_hit, clear the outstanding count and the last_seen flag, and enter ACCUM next cycle.
REQ-006 SHALL ignore start outside IDLE, and ignore done/issue/last in IDLE.
REQ-007 SHALL, in ACCUM, increment the outstanding count on issue and decrement it on done; issue and done in the same cycle leave the count unchanged.
REQ-008 SHALL, when issue arrives with the count at its maximum (2^CNT_W-1), leave the count unchanged; upstream never exceeds this.
REQ-009 SHALL set last_seen on last in ACCUM.
REQ-010 SHALL, on done with isected=1 and t strictly less than tmax_out, update tmax_out=t, res_t=t, res_u=u, res_v=v, res_id=prim_id, res_hit=1, all on the same edge.
REQ-011 SHALL compare t as a non-negative float using unsigned comparison of bits [30:0]; a result with t[31]=1 or t exponent 8'hFF SHALL be discarded.
REQ-012 SHALL discard equal t, so the earlier-returned hit wins ties.
REQ-013 SHALL enter REPORT on the edge after which the count equals 0 and last_seen is set, including the case where last and the final done arrive in the same cycle.
REQ-014 SHALL, on last with no tests outstanding, enter REPORT one cycle after last.
REQ-015 SHALL drive res_valid=1 only in REPORT, with the record held stable until res_ready=1; REPORT with res_ready returns to IDLE next cycle.
REQ-016 SHALL, on a miss (res_hit=0), report res_t=tmax_init and res_u=res_v=res_id=0.
REQ-017 SHALL produce all outputs from registers, with no combinational input-to-output path.

Reset
REQ-018 SHALL, on reset_n low at any time including mid-ray, asynchronously enter IDLE with tmax_out=32'h7F7FFFFF, busy=0, res_valid=0, res_hit=0, res_t=res_u=res_v=0, res_id=0, count=0, and last_seen=0.

Configuration
REQ-019 SHALL, with HIT_ACCUM_STATS_EN defined, add outputs n_tests[15:0] (done count) and n_hits[15:0] (accepted-hit count), both saturating, cleared on start and reset, and held through REPORT.
REQ-020 SHALL, without HIT_ACCUM_STATS_EN, omit these ports and counters; all other behaviour is identical.

Verification
REQ-021 SHALL verify: start with tmax_init=32'h7F7FFFFF; issue x3; last; dones with hits t=32'h40000000 (id 1), 32'h3F800000 (id 2), 32'h3F800000 (id 3) -> res_t=32'h3F800000, res_id=2, tmax_out updates after the 1st and 2nd done only.
REQ-022 SHALL verify: tmax_init=32'h3F000000, one done with a hit at t=32'h3F800000 -> res_hit=0, res_t=32'h3F000000.
REQ-023 SHALL verify: last with zero issues -> res_valid one cycle later with res_hit=0.
REQ-024 SHALL verify: issue and done in the same cycle, then last coincident with the final done -> REPORT entered on the next edge, with no early REPORT.
REQ-025 SHALL verify: res_ready held low for 5 cycles -> record stable; a start during REPORT is ignored; res_ready=1 -> IDLE next cycle.
REQ-026 SHALL verify: reset_n pulsed low mid-ACCUM -> all outputs at their REQ-018 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hit_accum.sv
// -----------------------------------------------------------------------------
// hit_accum -- closest-hit accumulator for one ray
//
// Collects the results of the ray/triangle intersection tests issued for a ray
// and keeps the closest accepted hit. The running closest t is fed back to the
// intersection unit as its tmax. Once the ray's last test has been issued and
// every outstanding result has returned, the final hit record is presented
// with a valid/ready handshake.
//
// Parameters
//   ID_W   triangle index width
//   CNT_W  outstanding-test counter width
//
// Ports
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   start, tmax_init   begin a new ray and latch its initial tmax (IDLE only)
//   issue              one test issued this cycle
//   last               no further issues for this ray (may coincide with issue)
//   done, isected      result strobe and hit flag
//   t, u, v, prim_id   hit parameters and triangle index of the returning result
//   tmax_out           current closest t
//   busy               ray in progress (ACCUM or REPORT)
//   res_valid/ready    final record handshake
//   res_hit, res_t, res_u, res_v, res_id   final record
//
// Configuration macro
//   HIT_ACCUM_STATS_EN  adds n_tests / n_hits saturating statistics outputs
// -----------------------------------------------------------------------------
module hit_accum #(
    parameter int ID_W  = 16,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [31:0]     tmax_init,
    input  logic            issue,
    input  logic            last,
    input  logic            done,
    input  logic            isected,
    input  logic [31:0]     t,
    input  logic [31:0]     u,
    input  logic [31:0]     v,
    input  logic [ID_W-1:0] prim_id,
    output logic [31:0]     tmax_out,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_hit,
    output logic [31:0]     res_t,
    output logic [31:0]     res_u,
    output logic [31:0]     res_v,
    output logic [ID_W-1:0] res_id
`ifdef HIT_ACCUM_STATS_EN
    ,
    output logic [15:0]     n_tests,
    output logic [15:0]     n_hits
`endif
);

    localparam logic [31:0]      TMAX_RST = 32'h7F7FFFFF;  // largest finite float
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            last_seen_q, last_seen_d;
    logic [31:0]     tmax_q, tmax_d;
    logic            res_hit_q, res_hit_d;
    logic [31:0]     res_t_q, res_t_d;
    logic [31:0]     res_u_q, res_u_d;
    logic [31:0]     res_v_q, res_v_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic            busy_q, busy_d;
    logic            res_valid_q, res_valid_d;
    logic            hit_ok;

    // t is treated as a non-negative float: for such values the raw bit pattern
    // orders the same as the value, so bits [30:0] compare as unsigned. Negative
    // t and Inf/NaN are dropped. Equal t is rejected so the first hit wins ties.
    assign hit_ok = (state_q == ACCUM) && done && isected &&
                    !t[31] && (t[30:23] != 8'hFF) &&
                    (t[30:0] < tmax_q[30:0]);

    // State register and all datapath/output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            tmax_q      <= TMAX_RST;
            res_hit_q   <= 1'b0;
            res_t_q     <= '0;
            res_u_q     <= '0;
            res_v_q     <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            tmax_q      <= tmax_d;
            res_hit_q   <= res_hit_d;
            res_t_q     <= res_t_d;
            res_u_q     <= res_u_d;
            res_v_q     <= res_v_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Datapath: ray setup, outstanding count, closest-hit update
    always_comb begin
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        tmax_d      = tmax_q;
        res_hit_d   = res_hit_q;
        res_t_d     = res_t_q;
        res_u_d     = res_u_q;
        res_v_d     = res_v_q;
        res_id_d    = res_id_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Preload the record with the miss values; a hit overwrites it.
                    cnt_d       = '0;
                    last_seen_d = 1'b0;
                    tmax_d      = tmax_init;
                    res_hit_d   = 1'b0;
                    res_t_d     = tmax_init;
                    res_u_d     = '0;
                    res_v_d     = '0;
                    res_id_d    = '0;
                end
            end
            ACCUM: begin
                if (issue && !done) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                end else if (done && !issue) begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                end
                if (last) last_seen_d = 1'b1;
                if (hit_ok) begin
                    tmax_d    = t;
                    res_hit_d = 1'b1;
                    res_t_d   = t;
                    res_u_d   = u;
                    res_v_d   = v;
                    res_id_d  = prim_id;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic; the ACCUM exit looks at the post-edge count and flag so
    // a last coinciding with the final done still reports on the next edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if ((cnt_d == '0) && last_seen_d) state_d = REPORT;
            REPORT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so busy/res_valid are plain flops
    always_comb begin
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == REPORT);
    end

    assign tmax_out  = tmax_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_hit   = res_hit_q;
    assign res_t     = res_t_q;
    assign res_u     = res_u_q;
    assign res_v     = res_v_q;
    assign res_id    = res_id_q;

`ifdef HIT_ACCUM_STATS_EN
    logic [15:0] n_tests_q, n_tests_d;
    logic [15:0] n_hits_q, n_hits_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_tests_q <= '0;
            n_hits_q  <= '0;
        end else begin
            n_tests_q <= n_tests_d;
            n_hits_q  <= n_hits_d;
        end
    end

    // Counters only move in ACCUM, so they hold their final values in REPORT.
    always_comb begin
        n_tests_d = n_tests_q;
        n_hits_d  = n_hits_q;
        if ((state_q == IDLE) && start) begin
            n_tests_d = '0;
            n_hits_d  = '0;
        end else if (state_q == ACCUM) begin
            if (done && (n_tests_q != 16'hFFFF)) n_tests_d = n_tests_q + 16'd1;
            if (hit_ok && (n_hits_q != 16'hFFFF)) n_hits_d = n_hits_q + 16'd1;
        end
    end

    assign n_tests = n_tests_q;
    assign n_hits  = n_hits_q;
`endif

endmodule

// File: tb/tb_hit_accum.sv
// -----------------------------------------------------------------------------
// tb_hit_accum -- directed self-checking bench for hit_accum
//
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_hit_accum;

    localparam int ID_W  = 16;
    localparam int CNT_W = 6;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [31:0]     tmax_init;
    logic            issue;
    logic            last;
    logic            done;
    logic            isected;
    logic [31:0]     t, u, v;
    logic [ID_W-1:0] prim_id;
    logic [31:0]     tmax_out;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic            res_hit;
    logic [31:0]     res_t, res_u, res_v;
    logic [ID_W-1:0] res_id;
`ifdef HIT_ACCUM_STATS_EN
    logic [15:0]     n_tests, n_hits;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    hit_accum #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .tmax_init (tmax_init),
        .issue     (issue),
        .last      (last),
        .done      (done),
        .isected   (isected),
        .t         (t),
        .u         (u),
        .v         (v),
        .prim_id   (prim_id),
        .tmax_out  (tmax_out),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hit   (res_hit),
        .res_t     (res_t),
        .res_u     (res_u),
        .res_v     (res_v),
        .res_id    (res_id)
`ifdef HIT_ACCUM_STATS_EN
        ,
        .n_tests   (n_tests),
        .n_hits    (n_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_result(input logic d, input logic hit, input logic [31:0] tt,
                              input logic [31:0] uu, input logic [31:0] vv,
                              input logic [ID_W-1:0] id);
        done    = d;
        isected = hit;
        t       = tt;
        u       = uu;
        v       = vv;
        prim_id = id;
    endtask

    initial begin
        reset_n   = 1'b1;
        start     = 1'b0;
        tmax_init = '0;
        issue     = 1'b0;
        last      = 1'b0;
        res_ready = 1'b0;
        set_result(1'b0, 1'b0, '0, '0, '0, '0);

        // ---------------- reset values ----------------
        #2 reset_n = 1'b0;
        #1;
        chk("rst_tmax",  tmax_out, 32'h7F7FFFFF);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_hit",   {31'd0, res_hit}, 32'd0);
        chk("rst_t",     res_t, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // ---------------- ray 1: three hits, tie on the third ----------------
        start = 1'b1; tmax_init = 32'h7F7FFFFF;
        step();
        start = 1'b0;
        chk("r1_busy", {31'd0, busy}, 32'd1);
        chk("r1_tmax0", tmax_out, 32'h7F7FFFFF);
        issue = 1'b1;
        step(); step(); step();
        issue = 1'b0; last = 1'b1;
        step();
        last = 1'b0;
        chk("r1_novalid_a", {31'd0, res_valid}, 32'd0);
        set_result(1'b1, 1'b1, 32'h40000000, 32'h11111111, 32'h1111AAAA, 16'd1);
        step();
        chk("r1_tmax1", tmax_out, 32'h40000000);
        chk("r1_novalid_b", {31'd0, res_valid}, 32'd0);
        set_result(1'b1, 1'b1, 32'h3F800000, 32'h22222222, 32'h2222AAAA, 16'd2);
        step();
        chk("r1_tmax2", tmax_out, 32'h3F800000);
        chk("r1_novalid_c", {31'd0, res_valid}, 32'd0);
        set_result(1'b1, 1'b1, 32'h3F800000, 32'h33333333, 32'h3333AAAA, 16'd3);
        step();
        set_result(1'b0, 1'b0, '0, '0, '0, '0);
        chk("r1_tmax3", tmax_out, 32'h3F800000);
        chk("r1_valid", {31'd0, res_valid}, 32'd1);
        chk("r1_hit",   {31'd0, res_hit}, 32'd1);
        chk("r1_t",     res_t, 32'h3F800000);
        chk("r1_u",     res_u, 32'h22222222);
        chk("r1_v",     res_v, 32'h2222AAAA);
        chk("r1_id",    {16'd0, res_id}, 32'd2);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("r1_idle_valid", {31'd0, res_valid}, 32'd0);
        chk("r1_idle_busy",  {31'd0, busy}, 32'd0);

        // ---------------- ray 2: negative t and far t both discarded ----------------
        start = 1'b1; tmax_init = 32'h3F000000;
        step();
        start = 1'b0;
        issue = 1'b1;
        step();
        last = 1'b1;
        step();
        issue = 1'b0; last = 1'b0;
        set_result(1'b1, 1'b1, 32'hBF800000, 32'h44444444, 32'h44444444, 16'd4);
        step();
        chk("r2_neg_tmax",  tmax_out, 32'h3F000000);
        chk("r2_novalid",   {31'd0, res_valid}, 32'd0);
        set_result(1'b1, 1'b1, 32'h3F800000, 32'h55555555, 32'h55555555, 16'd5);
        step();
        set_result(1'b0, 1'b0, '0, '0, '0, '0);
        chk("r2_valid", {31'd0, res_valid}, 32'd1);
        chk("r2_hit",   {31'd0, res_hit}, 32'd0);
        chk("r2_t",     res_t, 32'h3F000000);
        chk("r2_u",     res_u, 32'd0);
        chk("r2_v",     res_v, 32'd0);
        chk("r2_id",    {16'd0, res_id}, 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // ---------------- ray 3: last with zero issues ----------------
        start = 1'b1; tmax_init = 32'h42000000;
        step();
        start = 1'b0;
        chk("r3_novalid", {31'd0, res_valid}, 32'd0);
        last = 1'b1;
        step();
        last = 1'b0;
        chk("r3_valid", {31'd0, res_valid}, 32'd1);
        chk("r3_hit",   {31'd0, res_hit}, 32'd0);
        chk("r3_t",     res_t, 32'h42000000);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // ---------------- done in IDLE is ignored ----------------
        set_result(1'b1, 1'b1, 32'h3E000000, 32'h66666666, 32'h66666666, 16'd6);
        issue = 1'b1; last = 1'b1;
        step();
        set_result(1'b0, 1'b0, '0, '0, '0, '0);
        issue = 1'b0; last = 1'b0;
        chk("idle_tmax", tmax_out, 32'h42000000);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- ray 4: issue+done together, last with final done ----------------
        start = 1'b1; tmax_init = 32'h7F7FFFFF;
        step();
        start = 1'b0;
        issue = 1'b1;
        step();
        set_result(1'b1, 1'b0, 32'h3F000000, '0, '0, 16'd7);
        step();
        issue = 1'b0;
        chk("r4_novalid_a", {31'd0, res_valid}, 32'd0);
        chk("r4_busy",      {31'd0, busy}, 32'd1);
        set_result(1'b1, 1'b1, 32'h3E800000, 32'h77777777, 32'h7777AAAA, 16'd8);
        last = 1'b1;
        step();
        last = 1'b0;
        set_result(1'b0, 1'b0, '0, '0, '0, '0);
        chk("r4_valid", {31'd0, res_valid}, 32'd1);
        chk("r4_hit",   {31'd0, res_hit}, 32'd1);
        chk("r4_t",     res_t, 32'h3E800000);
        chk("r4_id",    {16'd0, res_id}, 32'd8);

        // ---------------- hold in REPORT with start ignored ----------------
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tmax_init = 32'h12345678;
            step();
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_t",     res_t, 32'h3E800000);
            chk("hold_u",     res_u, 32'h77777777);
            chk("hold_tmax",  tmax_out, 32'h3E800000);
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("rel_valid", {31'd0, res_valid}, 32'd0);
        chk("rel_busy",  {31'd0, busy}, 32'd0);
        step();
        chk("rel_busy2", {31'd0, busy}, 32'd0);

        // ---------------- ray 5: asynchronous reset mid-ACCUM ----------------
        start = 1'b1; tmax_init = 32'h40400000;
        step();
        start = 1'b0;
        issue = 1'b1;
        step();
        issue = 1'b0;
        set_result(1'b1, 1'b1, 32'h3F800000, 32'h88888888, 32'h88888888, 16'd9);
        step();
        set_result(1'b0, 1'b0, '0, '0, '0, '0);
        chk("r5_tmax", tmax_out, 32'h3F800000);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_tmax",  tmax_out, 32'h7F7FFFFF);
        chk("ar_busy",  {31'd0, busy}, 32'd0);
        chk("ar_valid", {31'd0, res_valid}, 32'd0);
        chk("ar_hit",   {31'd0, res_hit}, 32'd0);
        chk("ar_t",     res_t, 32'd0);
        chk("ar_u",     res_u, 32'd0);
        chk("ar_v",     res_v, 32'd0);
        chk("ar_id",    {16'd0, res_id}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("ar_idle_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
